// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one op in flight.
// Define MULDIV_EARLY_OUT_EN to complete zero/divide-by-zero/overflow/|a|<|b| cases straight from IDLE.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  src_a_i,
  input  logic [XLEN-1:0]  src_b_i,
  input  logic [TAG_W-1:0] rd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] rd_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [2:0]       op;
  logic [TAG_W-1:0] rd_q;
  logic             neg;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  opb;
  logic [CW-1:0]    cnt;

  logic            sgn_a_op, sgn_b_op, neg_a, neg_b, b_zero, acc_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sgn_a_op = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
               (funct3_i == 3'b100) || (funct3_i == 3'b110);
    sgn_b_op = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    neg_a    = sgn_a_op & src_a_i[XLEN-1];
    neg_b    = sgn_b_op & src_b_i[XLEN-1];
    mag_a    = neg_a ? -src_a_i : src_a_i;
    mag_b    = neg_b ? -src_b_i : src_b_i;
    b_zero   = (src_b_i == '0);
    // Divide by zero must not negate the all-ones quotient; remainder follows the dividend.
    if (funct3_i[2])
      acc_neg = funct3_i[1] ? neg_a : ((neg_a ^ neg_b) & ~b_zero);
    else
      acc_neg = neg_a ^ neg_b;
  end

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    addend    = lo[0] ? opb : '0;
    mul_sum   = {1'b0, hi} + {1'b0, addend};
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod = neg ? -{hi, lo} : {hi, lo};
    if (op[2])
      fix_res = op[1] ? (neg ? -hi : hi) : (neg ? -lo : lo);
    else if (op[1:0] == 2'b00)
      fix_res = prod[XLEN-1:0];
    else
      fix_res = prod[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            early;
  logic            ovf;
  logic [XLEN-1:0] early_res;

  always_comb begin
    ovf       = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
    early     = 1'b0;
    early_res = '0;
    if (funct3_i[2]) begin
      if (b_zero) begin
        early     = 1'b1;
        early_res = funct3_i[1] ? src_a_i : '1;
      end else if (ovf) begin
        early     = 1'b1;
        early_res = funct3_i[1] ? '0 : src_a_i;
      end else if (mag_a < mag_b) begin
        early     = 1'b1;
        early_res = funct3_i[1] ? src_a_i : '0;
      end
    end else if ((src_a_i == '0) || b_zero) begin
      early = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      op       <= '0;
      rd_q     <= '0;
      neg      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            op     <= funct3_i;
            rd_q   <= rd_i;
            neg    <= acc_neg;
            busy_o <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (early) begin
              result_o <= early_res;
              rd_o     <= rd_i;
              done_o   <= 1'b1;
              state    <= DONE;
            end else
`endif
            begin
              hi    <= '0;
              lo    <= mag_a;
              opb   <= mag_b;
              cnt   <= CW'(XLEN);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (op[2]) begin
              // Restoring step: keep the shifted remainder when the subtract borrows.
              hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
              lo <= {lo[XLEN-2:0], ~div_diff[XLEN]};
            end else begin
              hi <= mul_sum[XLEN:1];
              lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
            if (cnt == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (flush_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            result_o <= fix_res;
            rd_o     <= rd_q;
            done_o   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected results, negedge monitor pops on done_o.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .flush_i(flush_i),
    .funct3_i(funct3_i), .src_a_i(src_a_i), .src_b_i(src_b_i), .rd_i(rd_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (reset_i === 1'b1 && done_o === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done actual result=%h rd=%0d expected no done_o", result_o, rd_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result_o, e.res);
        chk("rd", {27'd0, rd_o}, {27'd0, e.rd});
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("busy_at_done", {31'd0, busy_o}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] er, input bit special,
                       input bit expect_done);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1; funct3_i = f; src_a_i = a; src_b_i = b; rd_i = r;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      if (busy_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("accept_busy", {31'd0, seen}, 32'd1);
    if (seen && expect_done) begin
      e.res = er;
      e.rd  = r;
      e.lat = (special && EARLY) ? 1 : XLEN + 2;
      e.acc = cyc;
      sb_q.push_back(e);
    end
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (!busy_o) break;
    end
    chk("idle_timeout_busy", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r, input logic [31:0] er, input bit special);
    issue(f, a, b, r, er, special, 1'b1);
    wait_idle();
  endtask

  initial begin
    reset_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; src_a_i = '0; src_b_i = '0; rd_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_rd", {27'd0, rd_o}, 32'd0);
    reset_i = 1'b1;

    run(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
    run(3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 1'b0);
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b0);
    run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 1'b0);
    run(3'b001, 32'hFFFFFFFE, 32'd3,        5'd17, 32'hFFFFFFFF, 1'b0);
    run(3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 1'b0);
    run(3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1'b0);
    run(3'b101, 32'hFFFFFFFE, 32'h10,       5'd7,  32'h0FFFFFFF, 1'b0);
    run(3'b100, 32'd7,        32'hFFFFFFFD, 5'd15, 32'hFFFFFFFE, 1'b0);
    run(3'b110, 32'd7,        32'hFFFFFFFD, 5'd16, 32'h00000001, 1'b0);
    run(3'b100, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1'b1);
    run(3'b110, 32'd5,        32'd0,        5'd9,  32'd5,        1'b1);
    run(3'b100, 32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFFF, 1'b1);
    run(3'b110, 32'hFFFFFFF9, 32'd0,        5'd19, 32'hFFFFFFF9, 1'b1);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1'b1);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        1'b1);
    run(3'b101, 32'd3,        32'd10,       5'd12, 32'd0,        1'b1);
    run(3'b111, 32'd3,        32'd10,       5'd13, 32'd3,        1'b1);
    run(3'b000, 32'd0,        32'd1234,     5'd14, 32'd0,        1'b1);

    // Flush in the middle of CALC: no done_o, then the unit must still work.
    issue(3'b101, 32'd100, 32'd7, 5'd20, 32'd0, 1'b0, 1'b0);
    repeat (10) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_done", {31'd0, done_o}, 32'd0);
    repeat (50) @(posedge clk_i);
    run(3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 1'b0);

    // Start pulse while busy is ignored: exactly one done_o for the first op.
    issue(3'b000, 32'd9, 32'd11, 5'd22, 32'd99, 1'b0, 1'b1);
    repeat (5) @(posedge clk_i);
    #1;
    start_i = 1'b1; funct3_i = 3'b100; src_a_i = 32'd50; src_b_i = 32'd5; rd_i = 5'd23;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_idle();
    repeat (50) @(posedge clk_i);

    // Reset mid-CALC: outputs clear at once and the aborted op never completes.
    issue(3'b101, 32'd1000, 32'd3, 5'd24, 32'd0, 1'b0, 1'b0);
    repeat (19) @(posedge clk_i);
    #1 reset_i = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy_o}, 32'd0);
    chk("midreset_done", {31'd0, done_o}, 32'd0);
    chk("midreset_result", result_o, 32'd0);
    chk("midreset_rd", {27'd0, rd_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    repeat (50) @(posedge clk_i);
    run(3'b111, 32'd3, 32'd10, 5'd25, 32'd3, 1'b1);

    repeat (5) @(posedge clk_i);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
